// File: rtl/sd_host_cmd_pkg.sv
// Shared definitions for the SD host CMD-line engine: response types, frame lengths, CRC7 and FSM codes.
// ST_BUSY only exists when SD_HOST_CMD_BUSY_EN is defined.
package sd_host_cmd_pkg;

  localparam logic [1:0] RSP_NONE     = 2'b00;
  localparam logic [1:0] RSP_48       = 2'b01;
  localparam logic [1:0] RSP_136      = 2'b10;
  localparam logic [1:0] RSP_48_NOCRC = 2'b11;

  localparam logic [7:0] FRAME_48  = 8'd48;
  localparam logic [7:0] FRAME_136 = 8'd136;

  // x^7 + x^3 + 1 with the x^7 term implied by the shift
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_RECV = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
`ifdef SD_HOST_CMD_BUSY_EN
  localparam logic [2:0] ST_BUSY = 3'd5;
`endif

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_host_cmd_crc7.sv
// Serial CRC7 register shared by command generation and response checking.
// clr together with cen restarts the CRC with din as the first bit.
module sd_host_crc7
  import sd_host_cmd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_cen,
  input  logic       i_din,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic [6:0] w_base;

  assign w_base = i_clr ? 7'h00 : r_crc;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_crc <= 7'h00;
    end else if (i_cen) begin
      r_crc <= crc7_step(w_base, i_din);
    end else if (i_clr) begin
      r_crc <= 7'h00;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_host_cmd.sv
// Host-side SD CMD-line engine: sends a 48-bit command, collects a 48/136-bit response, checks it.
// Define SD_HOST_CMD_BUSY_EN to add the R1b DAT0 busy wait (dat0_in, rsp_busy, busy_to).
module sd_host_cmd
  import sd_host_cmd_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int NCC     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [5:0]   i_cmd_idx,
  input  logic [31:0]  i_cmd_arg,
  input  logic [1:0]   i_rsp_type,
  input  logic         i_cmd_in,
`ifdef SD_HOST_CMD_BUSY_EN
  input  logic         i_dat0_in,
  input  logic         i_rsp_busy,
  output logic         o_busy_to,
`endif
  output logic         o_cmd_oe,
  output logic         o_cmd_od,
  output logic         o_busy,
  output logic         o_done,
  output logic [135:0] o_rsp_q,
  output logic         o_timeout,
  output logic         o_crc_err,
  output logic         o_idx_err
);

  localparam int NCR_W = (NCR_MAX > 2) ? $clog2(NCR_MAX) : 1;
  localparam int NCC_W = (NCC > 1) ? $clog2(NCC) : 1;
  // done lands exactly NCR_MAX clocks after the command end bit
  localparam logic [NCR_W-1:0] NCR_LAST = NCR_W'(NCR_MAX - 2);
  localparam logic [NCC_W-1:0] NCC_LAST = NCC_W'(NCC - 1);

  logic [2:0]       r_state;
  logic [7:0]       r_bit;
  logic [NCR_W-1:0] r_ncr;
  logic [NCC_W-1:0] r_gap;
  logic [39:0]      r_tx;
  logic [5:0]       r_idx;
  logic [1:0]       r_type;
  logic [135:0]     r_rsp;
  logic             r_done;
  logic             r_timeout;
  logic             r_crc_err;
  logic             r_idx_err;
`ifdef SD_HOST_CMD_BUSY_EN
  logic             r_rsp_busy;
  logic [15:0]      r_bcnt;
  logic             r_busy_to;
`endif

  logic [6:0]   w_crc;
  logic         w_crc_clr;
  logic         w_crc_cen;
  logic         w_crc_din;
  logic         w_tx_bit;
  logic [135:0] w_rsp_next;
  logic         w_last;
  logic         w_rx_crc_err;
  logic         w_rx_idx_err;

  sd_host_crc7 u_crc7 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_crc_clr),
    .i_cen (w_crc_cen),
    .i_din (w_crc_din),
    .o_crc (w_crc)
  );

  // R2 skips its 8 header bits, so its CRC restarts at received bit 8
  always_comb begin
    w_crc_clr = 1'b0;
    w_crc_cen = 1'b0;
    w_crc_din = i_cmd_in;
    case (r_state)
      ST_IDLE: w_crc_clr = i_start;
      ST_SEND: begin
        w_crc_cen = (r_bit < 8'd40);
        w_crc_din = r_tx[39];
      end
      ST_WAIT: begin
        w_crc_clr = ~i_cmd_in;
        w_crc_cen = ~i_cmd_in;
      end
      ST_RECV: begin
        if (r_type == RSP_136) begin
          w_crc_clr = (r_bit == 8'd8);
          w_crc_cen = (r_bit >= 8'd8) && (r_bit < 8'd128);
        end else begin
          w_crc_cen = (r_bit < 8'd40);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    if (r_bit < 8'd40) begin
      w_tx_bit = r_tx[39];
    end else if (r_bit < 8'd47) begin
      w_tx_bit = w_crc[3'd6 - r_bit[2:0]];
    end else begin
      w_tx_bit = 1'b1;
    end
  end

  assign w_rsp_next   = {r_rsp[134:0], i_cmd_in};
  assign w_last       = (r_bit == ((r_type == RSP_136) ? FRAME_136 : FRAME_48) - 8'd1);
  assign w_rx_crc_err = ~i_cmd_in | ((r_type != RSP_48_NOCRC) && (w_rsp_next[7:1] != w_crc));
  assign w_rx_idx_err = (r_type == RSP_48) && (w_rsp_next[45:40] != r_idx);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_bit     <= 8'd0;
      r_ncr     <= '0;
      r_gap     <= '0;
      r_tx      <= 40'd0;
      r_idx     <= 6'd0;
      r_type    <= RSP_NONE;
      r_rsp     <= 136'd0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_crc_err <= 1'b0;
      r_idx_err <= 1'b0;
`ifdef SD_HOST_CMD_BUSY_EN
      r_rsp_busy <= 1'b0;
      r_bcnt     <= 16'd0;
      r_busy_to  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ncr  <= '0;
      r_gap  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_tx      <= {2'b01, i_cmd_idx, i_cmd_arg};
            r_idx     <= i_cmd_idx;
            r_type    <= i_rsp_type;
            r_rsp     <= 136'd0;
            r_timeout <= 1'b0;
            r_crc_err <= 1'b0;
            r_idx_err <= 1'b0;
            r_bit     <= 8'd0;
            r_state   <= ST_SEND;
`ifdef SD_HOST_CMD_BUSY_EN
            r_rsp_busy <= i_rsp_busy;
            r_busy_to  <= 1'b0;
`endif
          end
        end
        ST_SEND: begin
          r_tx  <= {r_tx[38:0], 1'b0};
          r_bit <= r_bit + 8'd1;
          if (r_bit == FRAME_48 - 8'd1) begin
            r_bit <= 8'd0;
            if (r_type == RSP_NONE) begin
              r_done  <= 1'b1;
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!i_cmd_in) begin
            r_rsp   <= w_rsp_next;
            r_bit   <= 8'd1;
            r_state <= ST_RECV;
          end else if (r_ncr == NCR_LAST) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_GAP;
          end else begin
            r_ncr <= r_ncr + 1'b1;
          end
        end
        ST_RECV: begin
          r_rsp <= w_rsp_next;
          r_bit <= r_bit + 8'd1;
          if (w_last) begin
            r_crc_err <= w_rx_crc_err;
            r_idx_err <= w_rx_idx_err;
`ifdef SD_HOST_CMD_BUSY_EN
            if (r_rsp_busy && !w_rx_crc_err && !w_rx_idx_err) begin
              r_bcnt  <= 16'd0;
              r_state <= ST_BUSY;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_GAP;
            end
`else
            r_done  <= 1'b1;
            r_state <= ST_GAP;
`endif
          end
        end
`ifdef SD_HOST_CMD_BUSY_EN
        // first BUSY cycle ignores DAT0 so the card gets at least two clocks to pull it low
        ST_BUSY: begin
          r_bcnt <= r_bcnt + 16'd1;
          if (i_dat0_in && (r_bcnt != 16'd0)) begin
            r_done  <= 1'b1;
            r_state <= ST_GAP;
          end else if (r_bcnt == 16'hFFFF) begin
            r_busy_to <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_GAP;
          end
        end
`endif
        ST_GAP: begin
          if (r_gap == NCC_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_oe  = (r_state == ST_SEND);
  assign o_cmd_od  = (r_state == ST_SEND) ? w_tx_bit : 1'b1;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = r_done;
  assign o_rsp_q   = r_rsp;
  assign o_timeout = r_timeout;
  assign o_crc_err = r_crc_err;
  assign o_idx_err = r_idx_err;
`ifdef SD_HOST_CMD_BUSY_EN
  assign o_busy_to = r_busy_to;
`endif

endmodule
